// File: rtl/qea_host_seq.sv
// -----------------------------------------------------------------------------
// qea_host_seq
//
// Host-side bring-up sequencer for the QEA core. One run:
//   1. stream ins_num gate-context words from the host into CTX RAM,
//   2. write the |0...0> basis state into STATE RAM (amplitude 1.0 at addr 0),
//   3. pulse o_qea_start and wait for i_qea_complete,
//   4. read STATE RAM back and stream every state word to the host.
//
// Optional build macro:
//   QEA_SEQ_TIMER_EN  - when defined, o_exec_cycles counts RUN cycles
//                       (cleared on START, saturating, held until next START).
//                       When undefined the counter is absent and the port is 0.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_run, i_qbit_num, i_ins_num     run request and its configuration
//   i_ctx_valid/o_ctx_ready/i_ctx_data   host gate-context word stream
//   o_qea_start, i_qea_complete      QEA start pulse / completion level
//   o_qea_ctx_*                      CTX RAM write port
//   o_qea_state_*, i_qea_state_dout  STATE RAM port (read data 1 cycle late)
//   o_rd_valid/i_rd_ready/o_rd_data  result stream to the host
//   o_busy, o_done, o_cfg_err        status (done / cfg_err are 1-cycle pulses)
//   o_exec_cycles                    RUN-phase cycle count
//   o_dbg_state                      current FSM state encoding (IDLE = 0)
//
// Handshake rule for both streams: a word moves on a rising edge where
// valid and ready are both high; while valid is high and ready is low the
// sender holds its data unchanged.
// -----------------------------------------------------------------------------
module qea_host_seq #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_qea_start,
    input  logic                                 i_qea_complete,
    output logic                                 o_qea_ctx_en,
    output logic                                 o_qea_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
    output logic [PE_NUM-1:0]                    o_qea_state_ena,
    output logic [PE_NUM-1:0]                    o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_cfg_err,
    output logic [31:0]                          o_exec_cycles,
    output logic [2:0]                           o_dbg_state
);

    localparam int SAW  = STATE_ADDR_WIDTH;
    localparam int GCAW = GATE_CONTEXT_ADDR_WIDTH;
    localparam int GCDW = GATE_CONTEXT_DATA_WIDTH;
    localparam int SDW  = STATE_DATA_WIDTH;
    localparam int MQW  = MAX_QBIT_WIDTH;
    localparam int WW   = PE_NUM * SDW;

    localparam logic [MQW-1:0] QMIN = MQW'(PE_NUM_WIDTH);
    localparam logic [MQW-1:0] QMAX = MQW'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);

    // Amplitude 1.0 + 0.0i in the fixed-point complex format {real, imag}.
    localparam logic [DATA_WIDTH-1:0] ONE_RE   = DATA_WIDTH'(1) << NUM_FRAC_BIT;
    localparam logic [SDW-1:0]        ONE_AMP  = {ONE_RE, {DATA_WIDTH{1'b0}}};
    localparam logic [WW-1:0]         INIT_WORD = {ONE_AMP, {(WW-SDW){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_CTX = 3'd1,
        S_INIT     = 3'd2,
        S_START    = 3'd3,
        S_RUN      = 3'd4,
        S_READ     = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    state_e state_q, state_d;

    // Latched run configuration. Counters carry one extra bit so that a
    // full-size DEPTH (2**SAW) or a maximal ins_num never wraps.
    logic [GCAW-1:0] ins_q;
    logic [SAW:0]    depth_q;
    logic [GCAW:0]   ctx_cnt_q;
    logic [SAW:0]    addr_cnt_q;
    logic [SAW:0]    beat_cnt_q;

    logic            cfg_err_q;
    logic            ctx_en_q;
    logic [GCAW-1:0] ctx_addr_q;
    logic [GCDW-1:0] ctx_data_q;

    // Result FIFO (2 entries) plus one outstanding RAM read.
    logic [WW-1:0]   fifo_mem_q [2];
    logic            fifo_wr_q;
    logic            fifo_rd_q;
    logic [1:0]      fifo_cnt_q;
    logic            inflight_q;

    logic            cfg_ok;
    logic            rd_issue;
    logic            pop;

    assign cfg_ok = (i_qbit_num >= QMIN) && (i_qbit_num <= QMAX);
    assign pop    = (fifo_cnt_q != 2'd0) && i_rd_ready;

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        o_ctx_ready       = 1'b0;
        o_qea_start       = 1'b0;
        o_done            = 1'b0;
        o_qea_state_ena   = '0;
        o_qea_state_wea   = '0;
        o_qea_state_addra = '0;
        o_qea_state_dina  = '0;
        rd_issue          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_run && cfg_ok) begin
                    state_d = (i_ins_num == '0) ? S_INIT : S_LOAD_CTX;
                end
            end
            S_LOAD_CTX: begin
                o_ctx_ready = 1'b1;
                if (i_ctx_valid && ((ctx_cnt_q + 1'b1) == {1'b0, ins_q})) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                o_qea_state_ena   = '1;
                o_qea_state_wea   = '1;
                o_qea_state_addra = addr_cnt_q[SAW-1:0];
                if (addr_cnt_q == '0) begin
                    o_qea_state_dina = INIT_WORD;
                end
                if (addr_cnt_q == depth_q - 1'b1) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                o_qea_start = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                // Completion is only looked at from the cycle after START.
                if (i_qea_complete) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Issue only when the FIFO is guaranteed a free slot for the
                // returning word, counting the read already in flight.
                if ((addr_cnt_q != depth_q) &&
                    ((fifo_cnt_q + {1'b0, inflight_q}) < 2'd2)) begin
                    rd_issue = 1'b1;
                end
                if (rd_issue) begin
                    o_qea_state_ena   = '1;
                    o_qea_state_addra = addr_cnt_q[SAW-1:0];
                end
                if (pop && (beat_cnt_q == depth_q - 1'b1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ins_q         <= '0;
            depth_q       <= '0;
            ctx_cnt_q     <= '0;
            addr_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            cfg_err_q     <= 1'b0;
            ctx_en_q      <= 1'b0;
            ctx_addr_q    <= '0;
            ctx_data_q    <= '0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == S_IDLE) && i_run && !cfg_ok;
            ctx_en_q  <= 1'b0;

            if ((state_q == S_IDLE) && i_run && cfg_ok) begin
                ins_q      <= i_ins_num;
                depth_q    <= {{SAW{1'b0}}, 1'b1} << (i_qbit_num - QMIN);
                ctx_cnt_q  <= '0;
                addr_cnt_q <= '0;
                beat_cnt_q <= '0;
            end

            // Accepted context word becomes a CTX write on the next cycle.
            if ((state_q == S_LOAD_CTX) && i_ctx_valid) begin
                ctx_en_q   <= 1'b1;
                ctx_addr_q <= ctx_cnt_q[GCAW-1:0];
                ctx_data_q <= i_ctx_data;
                ctx_cnt_q  <= ctx_cnt_q + 1'b1;
            end

            // The address counter restarts at 0 when INIT ends, ready for READ.
            if (state_q == S_INIT) begin
                addr_cnt_q <= (addr_cnt_q == depth_q - 1'b1) ? '0 : addr_cnt_q + 1'b1;
            end
            if (rd_issue) begin
                addr_cnt_q <= addr_cnt_q + 1'b1;
            end

            inflight_q <= rd_issue;

            if (inflight_q) begin
                fifo_mem_q[fifo_wr_q] <= i_qea_state_dout;
                fifo_wr_q             <= ~fifo_wr_q;
            end
            if (pop) begin
                fifo_rd_q  <= ~fifo_rd_q;
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            case ({inflight_q, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

`ifdef QEA_SEQ_TIMER_EN
    logic [31:0] exec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q <= '0;
        end else if (state_q == S_START) begin
            exec_q <= '0;
        end else if ((state_q == S_RUN) && (exec_q != 32'hFFFF_FFFF)) begin
            exec_q <= exec_q + 32'd1;
        end
    end

    assign o_exec_cycles = exec_q;
`else
    assign o_exec_cycles = 32'd0;
`endif

    assign o_qea_ctx_en   = ctx_en_q;
    assign o_qea_ctx_wea  = ctx_en_q;
    assign o_qea_ctx_addr = ctx_addr_q;
    assign o_qea_ctx_data = ctx_data_q;
    assign o_rd_valid     = (fifo_cnt_q != 2'd0);
    assign o_rd_data      = fifo_mem_q[fifo_rd_q];
    assign o_busy         = (state_q != S_IDLE);
    assign o_cfg_err      = cfg_err_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_qea_host_seq.sv
// -----------------------------------------------------------------------------
// tb_qea_host_seq
//
// Directed bench for qea_host_seq. A behavioural STATE RAM (1-cycle read
// latency) answers the sequencer; "QEA results" are written into it while
// the sequencer waits in RUN, and the read-back stream is compared against
// those bench-generated words.
// -----------------------------------------------------------------------------
module tb_qea_host_seq;

    localparam int W = 256;
    localparam logic [W-1:0] INIT_W = {64'h40000000_00000000, 192'h0};

    logic          clk;
    logic          rst_n;
    logic          i_run;
    logic [5:0]    i_qbit_num;
    logic [15:0]   i_ins_num;
    logic          i_ctx_valid;
    logic          o_ctx_ready;
    logic [63:0]   i_ctx_data;
    logic          o_qea_start;
    logic          i_qea_complete;
    logic          o_qea_ctx_en;
    logic          o_qea_ctx_wea;
    logic [15:0]   o_qea_ctx_addr;
    logic [63:0]   o_qea_ctx_data;
    logic [3:0]    o_qea_state_ena;
    logic [3:0]    o_qea_state_wea;
    logic [15:0]   o_qea_state_addra;
    logic [W-1:0]  o_qea_state_dina;
    logic [W-1:0]  i_qea_state_dout;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [W-1:0]  o_rd_data;
    logic          o_busy;
    logic          o_done;
    logic          o_cfg_err;
    logic [31:0]   o_exec_cycles;
    logic [2:0]    o_dbg_state;

    qea_host_seq dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_run             (i_run),
        .i_qbit_num        (i_qbit_num),
        .i_ins_num         (i_ins_num),
        .i_ctx_valid       (i_ctx_valid),
        .o_ctx_ready       (o_ctx_ready),
        .i_ctx_data        (i_ctx_data),
        .o_qea_start       (o_qea_start),
        .i_qea_complete    (i_qea_complete),
        .o_qea_ctx_en      (o_qea_ctx_en),
        .o_qea_ctx_wea     (o_qea_ctx_wea),
        .o_qea_ctx_addr    (o_qea_ctx_addr),
        .o_qea_ctx_data    (o_qea_ctx_data),
        .o_qea_state_ena   (o_qea_state_ena),
        .o_qea_state_wea   (o_qea_state_wea),
        .o_qea_state_addra (o_qea_state_addra),
        .o_qea_state_dina  (o_qea_state_dina),
        .i_qea_state_dout  (i_qea_state_dout),
        .o_rd_valid        (o_rd_valid),
        .i_rd_ready        (i_rd_ready),
        .o_rd_data         (o_rd_data),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_cfg_err         (o_cfg_err),
        .o_exec_cycles     (o_exec_cycles),
        .o_dbg_state       (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- result pattern ----------------
    function automatic logic [W-1:0] pat(input int seed, input int idx);
        logic [W-1:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = 32'h5A5A_0000 ^ 32'(seed << 24) ^ 32'(idx * 16 + k);
        end
        return r;
    endfunction

    // ---------------- STATE RAM model ----------------
    logic [W-1:0] ram [0:63];
    logic         inject_req;
    int           inject_seed;

    always @(posedge clk) begin
        if (inject_req) begin
            for (int j = 0; j < 64; j++) ram[j] <= pat(inject_seed, j);
        end else if (|o_qea_state_ena) begin
            if (&o_qea_state_wea) ram[o_qea_state_addra[5:0]] <= o_qea_state_dina;
            else                  i_qea_state_dout <= ram[o_qea_state_addra[5:0]];
        end
    end

    // ---------------- monitor / capture ----------------
    logic [15:0]  ctx_addr_cap [$];
    logic [63:0]  ctx_data_cap [$];
    logic [15:0]  sw_addr_cap  [$];
    logic [W-1:0] sw_data_cap  [$];
    logic [W-1:0] beat_cap     [$];
    logic [W-1:0] exp_q        [$];
    int start_cnt, done_cnt, act_cnt;
    logic         hold_pending;
    logic [W-1:0] hold_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (!o_rd_valid || o_rd_data !== hold_data) begin
                    errors++;
                    $display("FAIL rd_hold: valid=%0b data=%h required valid=1 data=%h",
                             o_rd_valid, o_rd_data, hold_data);
                end
            end
            hold_pending = o_rd_valid && !i_rd_ready;
            hold_data    = o_rd_data;
            if (o_qea_ctx_en && o_qea_ctx_wea) begin
                ctx_addr_cap.push_back(o_qea_ctx_addr);
                ctx_data_cap.push_back(o_qea_ctx_data);
            end
            if ((o_qea_state_ena == 4'hF) && (o_qea_state_wea == 4'hF)) begin
                sw_addr_cap.push_back(o_qea_state_addra);
                sw_data_cap.push_back(o_qea_state_dina);
            end
            if (o_qea_start) start_cnt++;
            if (o_done) done_cnt++;
            if (o_qea_ctx_en || (|o_qea_state_ena) || o_qea_start) act_cnt++;
            if (o_rd_valid && i_rd_ready) beat_cap.push_back(o_rd_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_caps();
        ctx_addr_cap.delete();
        ctx_data_cap.delete();
        sw_addr_cap.delete();
        sw_data_cap.delete();
        beat_cap.delete();
        exp_q.delete();
        start_cnt = 0;
        done_cnt  = 0;
    endtask

    // Presents a 1-cycle run request; returns #1 after the sampling edge.
    task automatic do_run(input logic [5:0] qbit, input logic [15:0] ins);
        @(posedge clk); #1;
        i_run = 1'b1; i_qbit_num = qbit; i_ins_num = ins;
        @(posedge clk); #1;
        i_run = 1'b0;
    endtask

    task automatic feed_ctx(input logic [63:0] w, input int gap);
        bit ok;
        bit rdy;
        ok = 1'b0;
        i_ctx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        i_ctx_valid = 1'b1;
        i_ctx_data  = w;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            rdy = o_ctx_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        i_ctx_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL ctx_accept_timeout: word %h not accepted", w); end
    endtask

    // Returns #1 after the negedge on which o_qea_start is seen high.
    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_qea_start) begin ok = 1'b1; break; end
        end
        #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL start_timeout: o_qea_start never seen"); end
    endtask

    // Called while RUN: loads results, raises complete 'cyc' cycles after
    // START, then drains the result stream and checks it.
    task automatic run_and_read(input int seed, input int depth, input int cyc,
                                input bit rand_ready, input int exp_exec);
        bit ok;
        logic [W-1:0] e;
        logic [31:0]  exp_cycles;
        for (int i = 0; i < depth; i++) exp_q.push_back(pat(seed, i));
        inject_seed = seed;
        inject_req  = 1'b1;
        @(posedge clk); #1;
        inject_req  = 1'b0;
        repeat (cyc - 1) @(posedge clk);
        #1;
        i_qea_complete = 1'b1;
        @(posedge clk); #1;
        i_qea_complete = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (o_done) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            if (rand_ready) i_rd_ready = ($urandom_range(0, 99) < 30);
        end
        #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL done_timeout: o_done never seen"); end
        checks++;
        if (beat_cap.size() !== depth) begin
            errors++;
            $display("FAIL beat_count: got %0d required %0d", beat_cap.size(), depth);
        end
        for (int i = 0; i < depth; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (i >= beat_cap.size() || beat_cap[i] !== e) begin
                errors++;
                $display("FAIL beat[%0d]: got %h required %h", i,
                         (i < beat_cap.size()) ? beat_cap[i] : {W{1'bx}}, e);
            end
        end
`ifdef QEA_SEQ_TIMER_EN
        exp_cycles = 32'(exp_exec);
`else
        exp_cycles = 32'd0 & 32'(exp_exec);
`endif
        checks++;
        if (o_exec_cycles !== exp_cycles) begin
            errors++;
            $display("FAIL exec_cycles: got %0d required %0d", o_exec_cycles, exp_cycles);
        end
        @(negedge clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || done_cnt !== 1 || start_cnt !== 1) begin
            errors++;
            $display("FAIL run_end: busy=%0b done=%0b done_pulses=%0d start_cycles=%0d required 0 0 1 1",
                     o_busy, o_done, done_cnt, start_cnt);
        end
        i_rd_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                clear_caps();
                do_run(6'd4, 16'd3);
                feed_ctx(64'h1111_2222_3333_4444, 0);
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
            end
            @(negedge clk);
            checks++;
            if ({o_busy, o_ctx_ready, o_qea_start, o_qea_ctx_en, o_qea_ctx_wea,
                 o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena, o_qea_state_wea,
                 o_qea_state_addra, o_qea_state_dina, o_rd_valid, o_rd_data,
                 o_done, o_cfg_err, o_exec_cycles} !== '0) begin
                errors++;
                $display("FAIL reset_outputs phase %0d: busy=%0b ctx_en=%0b ena=%h rd_valid=%0b exec=%0d required all 0",
                         phase, o_busy, o_qea_ctx_en, o_qea_state_ena, o_rd_valid, o_exec_cycles);
            end
            checks++;
            if (o_dbg_state !== 3'd0) begin
                errors++;
                $display("FAIL reset_state phase %0d: got %0d required 0", phase, o_dbg_state);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic test_load_init();
        clear_caps();
        do_run(6'd4, 16'd3);
        feed_ctx(64'hAAAA_0000_0000_000A, 0);
        feed_ctx(64'hBBBB_0000_0000_000B, 2);
        feed_ctx(64'hCCCC_0000_0000_000C, 1);
        wait_start();
        checks++;
        if (ctx_addr_cap.size() !== 3 || ctx_addr_cap[0] !== 16'd0 || ctx_addr_cap[1] !== 16'd1 ||
            ctx_addr_cap[2] !== 16'd2) begin
            errors++;
            $display("FAIL ctx_addr: count=%0d required 3 writes at addr 0,1,2", ctx_addr_cap.size());
        end
        checks++;
        if (ctx_data_cap.size() !== 3 || ctx_data_cap[0] !== 64'hAAAA_0000_0000_000A ||
            ctx_data_cap[1] !== 64'hBBBB_0000_0000_000B || ctx_data_cap[2] !== 64'hCCCC_0000_0000_000C) begin
            errors++;
            $display("FAIL ctx_data: count=%0d required A,B,C", ctx_data_cap.size());
        end
        checks++;
        if (sw_addr_cap.size() !== 4) begin
            errors++;
            $display("FAIL state_write_count: got %0d required 4", sw_addr_cap.size());
        end
        for (int i = 0; i < 4 && i < sw_addr_cap.size(); i++) begin
            checks++;
            if (sw_addr_cap[i] !== 16'(i) || sw_data_cap[i] !== ((i == 0) ? INIT_W : '0)) begin
                errors++;
                $display("FAIL state_write[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                         i, sw_addr_cap[i], sw_data_cap[i], i, (i == 0) ? INIT_W : '0);
            end
        end
        checks++;
        if (start_cnt !== 1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_seen: start_cycles=%0d busy=%0b required 1 1", start_cnt, o_busy);
        end
    endtask

    task automatic test_run_read();
        i_rd_ready = 1'b1;
        run_and_read(1, 4, 20, 1'b0, 20);
    endtask

    task automatic test_random_ready();
        clear_caps();
        i_rd_ready = 1'b0;
        do_run(6'd5, 16'd1);
        feed_ctx(64'hDDDD_0000_0000_000D, 0);
        wait_start();
        checks++;
        if (sw_addr_cap.size() !== 8 || ctx_addr_cap.size() !== 1) begin
            errors++;
            $display("FAIL rand_setup: state writes=%0d ctx writes=%0d required 8 1",
                     sw_addr_cap.size(), ctx_addr_cap.size());
        end
        run_and_read(2, 8, 5, 1'b1, 5);
    endtask

    task automatic test_cfg_err();
        logic [5:0] bad [2];
        int act0;
        bad[0] = 6'd1;
        bad[1] = 6'd19;
        for (int b = 0; b < 2; b++) begin
            act0 = act_cnt;
            do_run(bad[b], 16'd3);
            @(negedge clk);
            checks++;
            if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse qbit=%0d: cfg_err=%0b busy=%0b required 1 0",
                         bad[b], o_cfg_err, o_busy);
            end
            @(negedge clk);
            checks++;
            if (o_cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_width qbit=%0d: got %0b required 0", bad[b], o_cfg_err);
            end
            repeat (5) @(negedge clk);
            #1;
            checks++;
            if (act_cnt !== act0 || o_dbg_state !== 3'd0) begin
                errors++;
                $display("FAIL cfg_err_quiet qbit=%0d: activity=%0d state=%0d required 0 0",
                         bad[b], act_cnt - act0, o_dbg_state);
            end
        end
    endtask

    task automatic test_run_ignored();
        clear_caps();
        i_rd_ready = 1'b1;
        do_run(6'd3, 16'd0);
        wait_start();
        // New request while RUN: must not change depth or restart.
        @(posedge clk); #1;
        i_run = 1'b1; i_qbit_num = 6'd4; i_ins_num = 16'd2;
        @(posedge clk); #1;
        i_run = 1'b0;
        run_and_read(3, 2, 10, 1'b0, 12);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (start_cnt !== 1 || ctx_addr_cap.size() !== 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL run_ignored: start_cycles=%0d ctx writes=%0d busy=%0b required 1 0 0",
                     start_cnt, ctx_addr_cap.size(), o_busy);
        end
    endtask

    task automatic test_ins_zero();
        clear_caps();
        i_rd_ready = 1'b1;
        do_run(6'd2, 16'd0);
        wait_start();
        checks++;
        if (ctx_addr_cap.size() !== 0 || sw_addr_cap.size() !== 1) begin
            errors++;
            $display("FAIL ins_zero_writes: ctx=%0d state=%0d required 0 1",
                     ctx_addr_cap.size(), sw_addr_cap.size());
        end else begin
            checks++;
            if (sw_addr_cap[0] !== 16'd0 || sw_data_cap[0] !== INIT_W) begin
                errors++;
                $display("FAIL ins_zero_init: addr=%0d data=%h required 0 %h",
                         sw_addr_cap[0], sw_data_cap[0], INIT_W);
            end
        end
        run_and_read(4, 1, 3, 1'b0, 3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n          = 1'b0;
        i_run          = 1'b0;
        i_qbit_num     = '0;
        i_ins_num      = '0;
        i_ctx_valid    = 1'b0;
        i_ctx_data     = '0;
        i_qea_complete = 1'b0;
        i_rd_ready     = 1'b0;
        inject_req     = 1'b0;
        inject_seed    = 0;
        act_cnt        = 0;
        start_cnt      = 0;
        done_cnt       = 0;
        hold_pending   = 1'b0;
        hold_data      = '0;
        repeat (3) @(posedge clk);

        test_reset();
        test_load_init();
        test_run_read();
        test_random_ready();
        test_cfg_err();
        test_run_ignored();
        test_ins_zero();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
